// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage register: occupancy states and
// the field layout of the 133-bit pipeline payload.
package pipe_pkg;

  localparam int INSTR_W = 32;
  localparam int PC_W    = 32;
  localparam int WREG_W  = 5;
  localparam int DATA_W  = 32;

  // Payload packed MSB-first as {instr, pc, wreg, alu_out, dm_out}.
  localparam int DM_LSB    = 0;
  localparam int ALU_LSB   = DM_LSB + DATA_W;
  localparam int WREG_LSB  = ALU_LSB + DATA_W;
  localparam int PC_LSB    = WREG_LSB + WREG_W;
  localparam int INSTR_LSB = PC_LSB + PC_W;
  localparam int PAYLOAD_W = INSTR_LSB + INSTR_W;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_state_t;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
    logic [WREG_W-1:0]  wreg;
    logic [DATA_W-1:0]  alu_out;
    logic [DATA_W-1:0]  dm_out;
  } stage_payload_t;

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int SCNT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inc,
  output logic [SCNT_W-1:0] count
);

  logic [SCNT_W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_reg <= '0;
    end else if (inc && (count_reg != {SCNT_W{1'b1}})) begin
      count_reg <= count_reg + SCNT_W'(1);
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with flush and a stall counter.
// Define PIPE_STAGE_SKID_EN for the 2-entry skid buffer with registered in_ready.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DW              = PAYLOAD_W,
  parameter bit ZERO_ON_INVALID = 1'b1,
  parameter int SCNT_W          = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DW-1:0]     in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DW-1:0]     out_data,
  input  logic              flush,
  output logic [SCNT_W-1:0] stall_cnt
);

  occ_state_t    state_reg;
  logic          out_valid_reg;
  logic [DW-1:0] out_data_reg;
  logic          in_fire;
  logic          out_fire;

  assign out_valid = out_valid_reg;
  assign out_fire  = out_valid_reg & out_ready;
  assign in_fire   = in_valid & in_ready;

`ifdef PIPE_STAGE_SKID_EN
  logic [DW-1:0] skid_data_reg;
  logic          in_ready_reg;

  // in_ready_reg tracks "not TWO" for the next cycle, so out_ready never
  // reaches in_ready combinationally; reset and flush only gate it.
  assign in_ready = in_ready_reg & ~flush & reset;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg     <= OCC_EMPTY;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      skid_data_reg <= '0;
      in_ready_reg  <= 1'b1;
    end else if (flush) begin
      state_reg     <= OCC_EMPTY;
      out_valid_reg <= 1'b0;
      in_ready_reg  <= 1'b1;
    end else begin
      case (state_reg)
        OCC_EMPTY: begin
          if (in_fire) begin
            state_reg     <= OCC_ONE;
            out_valid_reg <= 1'b1;
            out_data_reg  <= in_data;
          end
        end
        OCC_ONE: begin
          if (in_fire && out_fire) begin
            out_data_reg <= in_data;
          end else if (in_fire) begin
            state_reg     <= OCC_TWO;
            skid_data_reg <= in_data;
            in_ready_reg  <= 1'b0;
          end else if (out_fire) begin
            state_reg     <= OCC_EMPTY;
            out_valid_reg <= 1'b0;
          end
        end
        OCC_TWO: begin
          if (out_fire) begin
            state_reg    <= OCC_ONE;
            out_data_reg <= skid_data_reg;
            in_ready_reg <= 1'b1;
          end
        end
        default: begin
          state_reg     <= OCC_EMPTY;
          out_valid_reg <= 1'b0;
          in_ready_reg  <= 1'b1;
        end
      endcase
    end
  end
`else
  // Single entry: accept only when the held payload leaves this same cycle.
  assign in_ready = (out_ready | ~out_valid_reg) & ~flush & reset;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg     <= OCC_EMPTY;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
    end else if (flush) begin
      state_reg     <= OCC_EMPTY;
      out_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        OCC_EMPTY: begin
          if (in_fire) begin
            state_reg     <= OCC_ONE;
            out_valid_reg <= 1'b1;
            out_data_reg  <= in_data;
          end
        end
        OCC_ONE: begin
          if (in_fire) begin
            out_data_reg <= in_data;
          end else if (out_fire) begin
            state_reg     <= OCC_EMPTY;
            out_valid_reg <= 1'b0;
          end
        end
        default: begin
          state_reg     <= OCC_EMPTY;
          out_valid_reg <= 1'b0;
        end
      endcase
    end
  end
`endif

  generate
    if (ZERO_ON_INVALID) begin : g_zero_idle
      assign out_data = out_valid_reg ? out_data_reg : '0;
    end else begin : g_raw_idle
      assign out_data = out_data_reg;
    end
  endgenerate

  sat_counter #(
    .SCNT_W(SCNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .reset(reset),
    .inc  (out_valid_reg & ~out_ready),
    .count(stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: vector table, directed corner sequences and a
// randomized run checked against a queue-based occupancy model.
module tb_pipe_stage_reg;

  localparam int DW  = 133;
  localparam int SW  = 16;
  localparam int SW4 = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, in_valid, out_ready, flush;
  logic [DW-1:0] in_data;
  logic          in_ready, out_valid;
  logic [DW-1:0] out_data;
  logic [SW-1:0] stall_cnt;
  logic          in_ready4, out_valid4;
  logic [DW-1:0] out_data4;
  logic [SW4-1:0] stall_cnt4;

  pipe_stage_reg #(.DW(DW), .ZERO_ON_INVALID(1'b1), .SCNT_W(SW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .flush(flush), .stall_cnt(stall_cnt)
  );

  pipe_stage_reg #(.DW(DW), .ZERO_ON_INVALID(1'b1), .SCNT_W(SW4)) dut4 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready4),
    .in_data(in_data), .out_valid(out_valid4), .out_ready(out_ready),
    .out_data(out_data4), .flush(flush), .stall_cnt(stall_cnt4)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Model: the payloads held by the stage, oldest first.
  logic [DW-1:0] q[$];
  logic [DW-1:0] recv[$];
  int unsigned   m_stall = 0;
  int unsigned   m_stall4 = 0;
  bit            model_on = 1'b0;

  typedef struct {
    logic          rst;
    logic          iv;
    logic [DW-1:0] d;
    logic          ordy;
    logic          fl;
    bit            chk;
    logic          e_ir;
    logic          e_ov;
    logic [DW-1:0] e_od;
  } vec_t;
  vec_t tbl[12];

  task automatic chk_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %b expected %b", name, cyc, act, exp);
    end
  endtask

  task automatic chk_vec(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic logic m_in_ready();
    if (!reset || flush) return 1'b0;
`ifdef PIPE_STAGE_SKID_EN
    return q.size() < 2;
`else
    return out_ready || (q.size() == 0);
`endif
  endfunction

  task automatic check_model();
    logic [DW-1:0] exp_d;
    if (!model_on) return;
    exp_d = (q.size() > 0) ? q[0] : '0;
    chk_bit("in_ready", in_ready, m_in_ready());
    chk_bit("out_valid", out_valid, q.size() > 0);
    chk_vec("out_data", out_data, exp_d);
    chk_int("stall_cnt", int'(stall_cnt), int'(m_stall));
    chk_int("stall_cnt4", int'(stall_cnt4), int'(m_stall4));
  endtask

  task automatic model_update(input logic ir);
    if (!reset) begin
      q.delete();
      m_stall  = 0;
      m_stall4 = 0;
      model_on = 1'b1;
    end else begin
      if (q.size() > 0 && !out_ready) begin
        if (m_stall < (1 << SW) - 1) m_stall++;
        if (m_stall4 < (1 << SW4) - 1) m_stall4++;
      end
      if (flush) begin
        q.delete();
      end else begin
        if (q.size() > 0 && out_ready) void'(q.pop_front());
        if (in_valid && ir) q.push_back(in_data);
      end
    end
  endtask

  task automatic tick();
    logic ir;
    @(negedge clk);
    check_model();
    ir = m_in_ready();
    if (out_valid && out_ready) recv.push_back(out_data);
    @(posedge clk);
    model_update(ir);
    #1;
    cyc++;
  endtask

  task automatic drive(input logic r, input logic iv, input logic [DW-1:0] d,
                       input logic ordy, input logic fl);
    reset = r; in_valid = iv; in_data = d; out_ready = ordy; flush = fl;
  endtask

  initial begin
    logic [DW-1:0] src[$];
    logic [159:0]  rnd;
    logic          acc;

    tbl[0]  = '{1'b0, 1'b1, DW'(1), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0};
    tbl[1]  = '{1'b0, 1'b1, DW'(1), 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, '0};
    for (int i = 0; i < 8; i++) begin
      tbl[2+i] = '{1'b1, 1'b1, DW'(16 + i), 1'b1, 1'b0, 1'b1, 1'b1,
                   (i != 0), (i == 0) ? '0 : DW'(15 + i)};
    end
    tbl[10] = '{1'b1, 1'b0, '0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, DW'(23)};
    tbl[11] = '{1'b1, 1'b0, '0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, '0};

    // Reset and streaming vectors.
    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].rst, tbl[i].iv, tbl[i].d, tbl[i].ordy, tbl[i].fl);
      #1;
      if (tbl[i].chk) begin
        chk_bit("tbl_in_ready", in_ready, tbl[i].e_ir);
        chk_bit("tbl_out_valid", out_valid, tbl[i].e_ov);
        chk_vec("tbl_out_data", out_data, tbl[i].e_od);
      end
      $display("vec %0d: iv=%b d=%0h ordy=%b -> ir=%b ov=%b od=%0h",
               i, tbl[i].iv, tbl[i].d, tbl[i].ordy, in_ready, out_valid, out_data);
      tick();
    end

    // Backpressure: A, B, C with out_ready low for three cycles.
    src = '{DW'(10), DW'(11), DW'(12)};
    recv.delete();
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, src.size() > 0, (src.size() > 0) ? src[0] : '0, (k >= 3), 1'b0);
      #1;
      if (k == 2) chk_bit("bp_ready_drop", in_ready, 1'b0);
      if (k >= 1 && k <= 3) chk_vec("bp_hold", out_data, DW'(10));
      if (k == 3) chk_int("bp_stall", int'(stall_cnt), 2);
`ifndef PIPE_STAGE_SKID_EN
      if (out_valid) chk_bit("ns_ready_follow", in_ready, out_ready);
`endif
      acc = in_valid && in_ready;
      $display("bp %0d: iv=%b ir=%b ov=%b od=%0h ordy=%b stall=%0d",
               k, in_valid, in_ready, out_valid, out_data, out_ready, stall_cnt);
      tick();
      if (acc) void'(src.pop_front());
    end
    chk_int("bp_recv_count", recv.size(), 3);
    if (recv.size() == 3) begin
      chk_vec("bp_order0", recv[0], DW'(10));
      chk_vec("bp_order1", recv[1], DW'(11));
      chk_vec("bp_order2", recv[2], DW'(12));
    end

    // Flush while holding 0x5/0x6 with 0x7 offered.
    drive(1'b1, 1'b1, DW'(5), 1'b0, 1'b0); tick();
    drive(1'b1, 1'b1, DW'(6), 1'b0, 1'b0); tick();
    drive(1'b1, 1'b1, DW'(7), 1'b0, 1'b1);
    #1;
    chk_bit("flush_ready", in_ready, 1'b0);
    $display("flush: ir=%b ov=%b od=%0h", in_ready, out_valid, out_data);
    tick();
    recv.delete();
    drive(1'b1, 1'b0, '0, 1'b1, 1'b0);
    #1;
    chk_bit("flush_valid", out_valid, 1'b0);
    chk_vec("flush_data", out_data, '0);
    for (int k = 0; k < 3; k++) tick();
    chk_int("flush_no_emit", recv.size(), 0);
    $display("post-flush: ov=%b emitted=%0d", out_valid, recv.size());

    // Saturation of the 4-bit stall counter.
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0); tick();
    drive(1'b1, 1'b1, DW'(153), 1'b0, 1'b0); tick();
    drive(1'b1, 1'b0, '0, 1'b0, 1'b0);
    for (int k = 0; k < 20; k++) tick();
    chk_int("sat_cnt4", int'(stall_cnt4), 15);
    chk_int("sat_cnt16", int'(stall_cnt), 20);
    $display("saturation: stall_cnt4=%0d stall_cnt=%0d", stall_cnt4, stall_cnt);

    // Randomized traffic against the model.
    for (int k = 0; k < 400; k++) begin
      rnd = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      drive($urandom_range(0, 49) != 0, $urandom_range(0, 1) == 1, rnd[DW-1:0],
            $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
